// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub result stage.
//   W_DEF / CNT_W_DEF : default datapath and overflow-counter widths
//   flags_t           : status record stored with every result
//   MAX_POS / MAX_NEG : saturation limits at the default width
//   calc_flags()      : status flags from the raw adder outputs
package addsub_pkg;

  localparam int W_DEF     = 64;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic borrow;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);

  localparam logic [W_DEF-1:0] MAX_POS = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] MAX_NEG = {1'b1, {(W_DEF-1){1'b0}}};

  // Width-independent: only the sum's sign bit and zero test are needed.
  // Subtraction feeds ~b into the adder, so the effective sign of the
  // second operand is b_msb flipped.
  function automatic flags_t calc_flags(input logic carry,
                                        input logic sum_zero,
                                        input logic sum_msb,
                                        input logic mode,
                                        input logic a_msb,
                                        input logic b_msb);
    flags_t f;
    logic   b_eff_msb;
    b_eff_msb = b_msb ^ mode;
    f.carry   = carry;
    f.zero    = sum_zero;
    f.neg     = sum_msb;
    f.ovf     = (a_msb == b_eff_msb) && (sum_msb != a_msb);
    f.borrow  = mode && !carry;
    return f;
  endfunction

endpackage

// File: rtl/addsub_result_stage_if.sv
// Bus between the adder/subtractor, the result stage and its consumer.
// Handshake: a beat moves on a rising clock edge when valid and ready are
// both high; valid never depends on ready, and in_ready depends only on
// registered state of the stage.
//   master : upstream producer + downstream consumer (drives in_*, out_ready)
//   slave  : the result stage
// Parameter W: datapath width.
interface addsub_result_stage_if
  import addsub_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic         in_carry;
  logic         in_mode;
  logic         in_a_msb;
  logic         in_b_msb;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;
  logic         out_borrow;

  modport master (
    output in_valid, in_sum, in_carry, in_mode, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_neg,
           out_ovf, out_borrow
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_mode, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_neg,
           out_ovf, out_borrow
  );

endinterface

// File: rtl/addsub_res_fifo.sv
// Two-entry FIFO holding packed {result, flags} entries.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_*        : write side (push_ready = not full, from registered count)
//   pop_*         : read side (pop_data is the head, zero when empty)
//   occupancy     : number of stored entries 0..2
// Parameter DW: entry width.
module addsub_res_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [1:0]    occupancy
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // Full blocks a push even when a pop happens on the same edge, which keeps
  // push_ready free of any path from pop_ready.
  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_ready && pop_valid;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;
  assign occupancy  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave the count unchanged; the read pointer
      // moves on to the entry just written when occupancy was 1.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage behind an adder/subtractor: computes status flags (and, when
// enabled, a saturated result) at push time, buffers results in a 2-entry
// FIFO and counts signed overflows.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : addsub_result_stage_if slave (in_* from the adder, out_* to
//                the consumer)
//   ovf_cnt    : saturating count of accepted results with signed overflow
//   occupancy  : debug view of the FIFO fill level 0..2
// Build option: define ADDSUB_SAT_EN to clamp overflowing results to the
// most positive / most negative value; otherwise results wrap.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_result_stage_if.slave  bus,
  output logic [CNT_W-1:0]      ovf_cnt,
  output logic [1:0]            occupancy
);

  localparam int DW = W + FLAGS_W;

  flags_t        push_flags;
  flags_t        head_flags;
  logic [W-1:0]  push_result;
  logic [DW-1:0] head_data;
  logic          push_fire;
  logic          fifo_ready;

  assign push_flags = calc_flags(bus.in_carry, (bus.in_sum == '0),
                                 bus.in_sum[W-1], bus.in_mode,
                                 bus.in_a_msb, bus.in_b_msb);

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  // On overflow both operands share a's sign, which is the true sign of the
  // result; flags keep describing the wrapped sum.
  assign push_result = push_flags.ovf ? (bus.in_a_msb ? SAT_NEG : SAT_POS)
                                      : bus.in_sum;
`else
  assign push_result = bus.in_sum;
`endif

  assign bus.in_ready = fifo_ready;
  assign push_fire    = bus.in_valid && fifo_ready;

  addsub_res_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.in_valid),
    .push_ready (fifo_ready),
    .push_data  ({push_result, push_flags}),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head_data),
    .occupancy  (occupancy)
  );

  assign head_flags     = head_data[FLAGS_W-1:0];
  assign bus.out_result = head_data[DW-1:FLAGS_W];
  assign bus.out_carry  = head_flags.carry;
  assign bus.out_zero   = head_flags.zero;
  assign bus.out_neg    = head_flags.neg;
  assign bus.out_ovf    = head_flags.ovf;
  assign bus.out_borrow = head_flags.borrow;

  // Counted at acceptance, independent of when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (push_fire && push_flags.ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_addsub_result_stage.sv
module tb_addsub_result_stage;
  import addsub_pkg::*;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int W  = 64;
  localparam int CW = 16;
  localparam int EW = W + 5;
  localparam logic [63:0] P_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P_MIN = 64'h8000_0000_0000_0000;
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] ovf_cnt;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  addsub_result_stage_if #(.W(W)) bus ();

  addsub_result_stage #(.W(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ovf_cnt   (ovf_cnt),
    .occupancy (occupancy)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cnt;
  int            n_cmp;
  int            n_fail;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] head_act();
    return {bus.out_result, bus.out_carry, bus.out_zero, bus.out_neg,
            bus.out_ovf, bus.out_borrow};
  endfunction

  // Reference: interpret a, b as signed/unsigned numbers and judge the
  // outcome arithmetically rather than from sign bits.
  function automatic logic [EW-1:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic m);
    logic [64:0]       full;
    logic signed [65:0] sa, sb, tr;
    logic              ovf;
    logic [63:0]       res;
    full = m ? ({1'b0, a} - {1'b0, b} + 65'h1_0000_0000_0000_0000)
             : ({1'b0, a} + {1'b0, b});
    sa   = $signed({{2{a[63]}}, a});
    sb   = $signed({{2{b[63]}}, b});
    tr   = m ? (sa - sb) : (sa + sb);
    ovf  = (tr > SMAX) || (tr < SMIN);
    res  = full[63:0];
    if (SAT && ovf) res = (tr < 0) ? P_MIN : P_MAX;
    return {res, full[64], (full[63:0] == 64'd0), full[63], ovf, (m && (a < b))};
  endfunction

  // ---------------- driver ----------------
  // Called in the low clock phase: drives one cycle, checks the visible
  // state against the model, updates the model for the coming edge and
  // returns at the next falling edge.
  task automatic step(input logic v, input logic r, input logic [63:0] a,
                      input logic [63:0] b, input logic m, output bit accepted);
    logic [64:0]   full;
    logic [EW-1:0] e;
    int            occ;
    full = {1'b0, a} + {1'b0, (m ? ~b : b)} + {64'd0, m};
    bus.in_valid  = v;
    bus.out_ready = r;
    bus.in_sum    = full[63:0];
    bus.in_carry  = full[64];
    bus.in_mode   = m;
    bus.in_a_msb  = a[63];
    bus.in_b_msb  = b[63];
    #1;
    occ = exp_q.size();
    check("occupancy", EW'(occupancy), EW'(occ));
    check("in_ready", EW'(bus.in_ready), EW'(occ != 2));
    check("out_valid", EW'(bus.out_valid), EW'(occ != 0));
    check("ovf_cnt", EW'(ovf_cnt), EW'(exp_cnt));
    if (r && occ != 0) begin
      e = exp_q.pop_front();
      check("head", head_act(), e);
    end
    accepted = v && (occ != 2);
    if (accepted) begin
      e = model(a, b, m);
      exp_q.push_back(e);
      if (e[1] && exp_cnt != 32'hFFFF) exp_cnt++;
    end
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    logic [63:0] res;
    logic        c, z, n, o, bw;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    bit acc;
    int tcnt;
    int pushed;
    logic [63:0] a, b;
    logic m;

    n_cmp = 0; n_fail = 0; exp_cnt = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_sum = '0;
    bus.in_carry = 1'b0; bus.in_mode = 1'b0; bus.in_a_msb = 1'b0;
    bus.in_b_msb = 1'b0;

    //              a                       b                       m  result                          c  z  n  o  bw
    tbl[0] = '{P_MAX,                 64'd1,                  1'b0, SAT ? P_MAX : P_MIN,           0, 0, 1, 1, 0};
    tbl[1] = '{64'd5,                 64'd5,                  1'b1, 64'd0,                         1, 1, 0, 0, 0};
    tbl[2] = '{64'd3,                 64'd5,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFE,       0, 0, 1, 0, 1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE,    1, 0, 1, 0, 0};
    tbl[4] = '{P_MIN,                 P_MIN,                  1'b0, SAT ? P_MIN : 64'd0,           1, 1, 0, 1, 0};
    tbl[5] = '{P_MIN,                 64'd1,                  1'b1, SAT ? P_MIN : P_MAX,           1, 0, 0, 1, 0};
    tbl[6] = '{64'd0,                 64'd0,                  1'b1, 64'd0,                         1, 1, 0, 0, 0};

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", EW'(bus.out_valid), '0);
    check("rst_occupancy", EW'(occupancy), '0);
    check("rst_ovf_cnt", EW'(ovf_cnt), '0);
    check("rst_head", head_act(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: each vector pushed alone, checked one cycle later, then drained
    tcnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].m, acc);
      if (tbl[i].o) tcnt++;
      #1;
      check($sformatf("tbl%0d_valid", i), EW'(bus.out_valid), EW'(1));
      check($sformatf("tbl%0d_head", i), head_act(),
            {tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].o, tbl[i].bw});
      check($sformatf("tbl%0d_ovf_cnt", i), EW'(ovf_cnt), EW'(tcnt));
      step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    end

    // Back-pressure: three pushes, third refused, then ordered drain
    step(1'b1, 1'b0, 64'd0, 64'd1, 1'b0, acc);
    step(1'b1, 1'b0, 64'd0, 64'd2, 1'b0, acc);
    step(1'b1, 1'b0, 64'd0, 64'd3, 1'b0, acc);
    check("bp_third_refused", EW'(acc), EW'(0));
    #1;
    check("bp_in_ready_low", EW'(bus.in_ready), EW'(0));
    check("bp_head_first", EW'(bus.out_result), EW'(1));
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    #1;
    check("bp_head_second", EW'(bus.out_result), EW'(2));
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);

    // Push and pop on the same edge at occupancy 1
    step(1'b1, 1'b0, 64'd0, 64'd10, 1'b0, acc);
    step(1'b1, 1'b1, 64'd0, 64'd11, 1'b0, acc);
    #1;
    check("pp_occupancy", EW'(occupancy), EW'(1));
    check("pp_head_new", EW'(bus.out_result), EW'(11));
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = rnd64();
      b = rnd64();
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = P_MAX;
        2: a = P_MIN;
        3: b = P_MIN;
        default: ;
      endcase
      m = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           a, b, m, acc);
    end

    // Asynchronous reset with the FIFO full
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    step(1'b1, 1'b0, P_MAX, 64'd1, 1'b0, acc);
    step(1'b1, 1'b0, P_MAX, 64'd1, 1'b0, acc);
    #1;
    check("mid_full", EW'(occupancy), EW'(2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", EW'(bus.out_valid), '0);
    check("mid_rst_ovf_cnt", EW'(ovf_cnt), '0);
    check("mid_rst_head", head_act(), '0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", EW'(bus.in_ready), EW'(1));
    step(1'b1, 1'b1, 64'd0, 64'd42, 1'b0, acc);
    #1;
    check("post_rst_valid", EW'(bus.out_valid), EW'(1));
    check("post_rst_result", EW'(bus.out_result), EW'(42));
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);

    // Overflow counter saturation: 65535 overflows reach all-ones, one more
    // must not wrap
    pushed = 0;
    for (int i = 0; i < 70000 && pushed < 65536; i++) begin
      step(1'b1, 1'b1, P_MAX, 64'd1, 1'b0, acc);
      if (acc) pushed++;
    end
    check("sat_pushes", EW'(pushed), EW'(65536));
    #1;
    check("ovf_cnt_saturated", EW'(ovf_cnt), EW'(16'hFFFF));
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);
    step(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
